// File: rtl/aggregator_arb_pkg.sv
// Shared types and sizing helpers for the aggregator input arbiter.
// Imported by the picker and by the top-level arbiter.
package aggregator_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Counter width: one extra bit so FETCH_WIDTH-1 always fits.
  function automatic int cnt_width(input int fetch_width);
    return $clog2(fetch_width) + 1;
  endfunction

  // Requester index that follows `last` in circular order.
  function automatic int rr_next(input int last, input int offset, input int num_req);
    return (last + offset) % num_req;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: the first set request scanning from
// last_grant+1 around to last_grant itself wins.
module rr_priority_picker
  import aggregator_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] last_grant,
  output logic                any_req,
  output logic [ID_WIDTH-1:0] winner
);

  logic [ID_WIDTH-1:0] cand;
  logic                found;

  always_comb begin
    any_req = |req;
    winner  = '0;
    found   = 1'b0;
    cand    = '0;
    // The last granted requester is scanned last, so it only wins again alone.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_WIDTH'(rr_next(int'(last_grant), k, NUM_REQ));
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aggregator_input_arbiter.sv
// Shares one aggregator among NUM_REQ sender FIFOs, granting one sender at a
// time for exactly FETCH_WIDTH words so each aggregated group has one source.
module aggregator_input_arbiter
  import aggregator_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int FETCH_WIDTH = 4,
  parameter int NUM_REQ     = 4,
  parameter int ID_WIDTH    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] sender_data,
  input  logic [NUM_REQ-1:0]            sender_empty_n,
  output logic [NUM_REQ-1:0]            sender_deq,
  output logic [DATA_WIDTH-1:0]         agg_data,
  output logic                          agg_empty_n,
  input  logic                          agg_deq,
  output logic                          grant_valid,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          group_done,
  output logic [ID_WIDTH-1:0]           group_id
);

  localparam int                  CNT_WIDTH = cnt_width(FETCH_WIDTH);
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(FETCH_WIDTH - 1);
  localparam logic [ID_WIDTH-1:0]  LAST_ID   = ID_WIDTH'(NUM_REQ - 1);

  arb_state_t           state_reg;
  logic [CNT_WIDTH-1:0] count_reg;
  logic [ID_WIDTH-1:0]  last_grant_reg;

  logic                  any_req;
  logic [ID_WIDTH-1:0]   winner;
  logic                  take;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  rr_priority_picker #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_picker (
    .req        (sender_empty_n),
    .last_grant (last_grant_reg),
    .any_req    (any_req),
    .winner     (winner)
  );

  // Only the granted FIFO is visible downstream, and only while bursting.
  assign agg_empty_n = (state_reg == BURST) && sender_empty_n[grant_id];
  assign take        = agg_empty_n && agg_deq;
  assign agg_data    = data_arr[grant_id];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign data_arr[gi]   = sender_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign sender_deq[gi] = take && (grant_id == ID_WIDTH'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      last_grant_reg <= LAST_ID;
      grant_id       <= '0;
      grant_valid    <= 1'b0;
      group_done     <= 1'b0;
      group_id       <= '0;
    end else begin
      group_done <= 1'b0;
      if (state_reg == IDLE) begin
        if (any_req) begin
          state_reg   <= BURST;
          grant_id    <= winner;
          grant_valid <= 1'b1;
          count_reg   <= '0;
        end
      end else if (take) begin
        // Grant is held through empty cycles; only the final word releases it.
        if (count_reg == LAST_BEAT) begin
          state_reg      <= IDLE;
          grant_valid    <= 1'b0;
          last_grant_reg <= grant_id;
          count_reg      <= '0;
          group_done     <= 1'b1;
          group_id       <= grant_id;
        end else begin
          count_reg <= count_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_aggregator_input_arbiter.sv
// Bench: queue-modelled sender FIFOs and a group-collecting receiver around the
// arbiter; groups are checked for single-source consecutive words and fair order.
module tb_aggregator_input_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] sender_data;
  logic [3:0]  sender_empty_n;
  logic [3:0]  sender_deq;
  logic [15:0] agg_data;
  logic        agg_empty_n;
  logic        agg_deq;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic        group_done;
  logic [1:0]  group_id;

  aggregator_input_arbiter #(
    .DATA_WIDTH  (16),
    .FETCH_WIDTH (4),
    .NUM_REQ     (4),
    .ID_WIDTH    (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sender_data    (sender_data),
    .sender_empty_n (sender_empty_n),
    .sender_deq     (sender_deq),
    .agg_data       (agg_data),
    .agg_empty_n    (agg_empty_n),
    .agg_deq        (agg_deq),
    .grant_valid    (grant_valid),
    .grant_id       (grant_id),
    .group_done     (group_done),
    .group_id       (group_id)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [15:0] q [4][$];
  int          push_k [4];
  bit          push_en [4];
  int          push_pct = 100;
  int          ready_mode = 0;
  bit   [3:0]  pop_pend;
  bit          exp_done;
  int          exp_gid;
  bit          gap_chk;
  bit          grant_chk;
  int          exp_grant;
  int          last_src;
  logic [15:0] rx [$];
  int          gid_log [$];
  int          first_log [$];
  int          done_cyc [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input int last, input bit [3:0] ne);
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (last + k) % 4;
      if (ne[idx[1:0]]) return idx;
    end
    return 0;
  endfunction

  task automatic push_word(input int r);
    q[r].push_back(16'(r * 256 + push_k[r]));
    push_k[r]++;
  endtask

  task automatic clear_model();
    rx.delete();
    pop_pend  = '0;
    exp_done  = 1'b0;
    gap_chk   = 1'b0;
    grant_chk = 1'b0;
    last_src  = 3;
  endtask

  task automatic drive();
    for (int r = 0; r < 4; r++) begin
      sender_empty_n[r]      = (q[r].size() != 0);
      sender_data[r*16 +: 16] = (q[r].size() != 0) ? q[r][0] : 16'h0000;
    end
    if (ready_mode == 1)      agg_deq = 1'b1;
    else if (ready_mode == 2) agg_deq = ($urandom_range(0, 3) != 0);
    else                      agg_deq = 1'b0;
  endtask

  // Receiver-side view of the combinational outputs, sampled mid-cycle.
  task automatic sample();
    logic [3:0] exp_deq;
    bit   [3:0] ne;
    exp_deq = '0;
    if (gap_chk) begin
      chk("gap_agg_empty_n", 32'(agg_empty_n), 32'd0);
      chk("gap_grant_valid", 32'(grant_valid), 32'd0);
      gap_chk = 1'b0;
    end
    chk("agg_empty_n", 32'(agg_empty_n), 32'(grant_valid && (q[grant_id].size() != 0)));
    if (agg_empty_n && agg_deq) begin
      if (agg_data[15:10] == 6'd0 && q[agg_data[9:8]].size() != 0) begin
        chk("deq_data", 32'(agg_data), 32'(q[agg_data[9:8]][0]));
        exp_deq[agg_data[9:8]]  = 1'b1;
        pop_pend[agg_data[9:8]] = 1'b1;
      end else begin
        chk("deq_source_known", 32'd0, 32'd1);
      end
      rx.push_back(agg_data);
      if (rx.size() == 4) begin
        for (int i = 1; i < 4; i++)
          chk("group_word", 32'(rx[i]), 32'(rx[0]) + 32'(i));
        exp_done = 1'b1;
        exp_gid  = int'(rx[0][15:8]);
        last_src = exp_gid;
        gap_chk  = 1'b1;
        gid_log.push_back(exp_gid);
        first_log.push_back(int'(rx[0]));
        done_cyc.push_back(cyc);
        $display("cycle %0d group id=%0d words=%0d,%0d,%0d,%0d",
                 cyc, exp_gid, rx[0], rx[1], rx[2], rx[3]);
        rx.delete();
      end
    end
    chk("sender_deq", 32'(sender_deq), 32'(exp_deq));
    for (int r = 0; r < 4; r++) ne[r] = (q[r].size() != 0);
    if (!grant_valid && ne != 4'd0) begin
      exp_grant = rr_pick(last_src, ne);
      grant_chk = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    chk("group_done", 32'(group_done), 32'(exp_done));
    if (exp_done) chk("group_id", 32'(group_id), 32'(exp_gid));
    if (grant_chk) begin
      chk("grant_valid", 32'(grant_valid), 32'd1);
      chk("grant_id", 32'(grant_id), 32'(exp_grant));
    end
    exp_done  = 1'b0;
    grant_chk = 1'b0;
    for (int r = 0; r < 4; r++)
      if (pop_pend[r] && q[r].size() != 0) void'(q[r].pop_front());
    pop_pend = '0;
    for (int r = 0; r < 4; r++)
      if (push_en[r] && q[r].size() < 8 && $urandom_range(0, 99) < push_pct)
        push_word(r);
    drive();
    #1;
    sample();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_grant_valid"}, 32'(grant_valid), 32'd0);
    chk({tag, "_grant_id"},    32'(grant_id),    32'd0);
    chk({tag, "_group_done"},  32'(group_done),  32'd0);
    chk({tag, "_group_id"},    32'(group_id),    32'd0);
    chk({tag, "_sender_deq"},  32'(sender_deq),  32'd0);
    chk({tag, "_agg_empty_n"}, 32'(agg_empty_n), 32'd0);
  endtask

  task automatic reset_begin();
    rst_n      = 1'b0;
    ready_mode = 0;
    push_pct   = 100;
    for (int r = 0; r < 4; r++) begin
      q[r].delete();
      push_k[r]  = 0;
      push_en[r] = 1'b0;
    end
    clear_model();
    gid_log.delete();
    first_log.delete();
    done_cyc.delete();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic reset_end();
    @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    drive();
    #1;
    sample();
  endtask

  task automatic wait_groups(input int n, input int budget);
    for (int i = 0; i < budget && gid_log.size() < n; i++) step();
    chk("groups_seen", 32'(gid_log.size()), 32'(n));
  endtask

  task automatic wait_rx(input int n, input int budget);
    for (int i = 0; i < budget && rx.size() < n; i++) step();
    chk("rx_words", 32'(rx.size()), 32'(n));
  endtask

  initial begin
    int exp_order [6] = '{0, 1, 2, 3, 0, 1};
    rst_n          = 1'b0;
    agg_deq        = 1'b0;
    sender_data    = '0;
    sender_empty_n = '0;

    // 1: only requester 2, continuously filled.
    reset_begin();
    push_en[2] = 1'b1;
    ready_mode = 1;
    reset_end();
    wait_groups(2, 100);
    if (gid_log.size() >= 2) begin
      chk("s1_id0", 32'(gid_log[0]), 32'd2);
      chk("s1_id1", 32'(gid_log[1]), 32'd2);
      chk("s1_first0", 32'(first_log[0]), 32'd512);
      chk("s1_first1", 32'(first_log[1]), 32'd516);
      chk("s1_spacing", 32'(done_cyc[1] - done_cyc[0]), 32'd5);
    end

    // 2: all four FIFOs full out of reset.
    reset_begin();
    for (int r = 0; r < 4; r++) repeat (8) push_word(r);
    ready_mode = 1;
    reset_end();
    wait_groups(6, 200);
    for (int i = 0; i < 6 && i < gid_log.size(); i++)
      chk("s2_order", 32'(gid_log[i]), 32'(exp_order[i]));

    // 3: requester 1 stalls mid-burst while requester 0 is full.
    reset_begin();
    repeat (2) push_word(1);
    ready_mode = 1;
    reset_end();
    wait_rx(2, 50);
    repeat (8) push_word(0);
    repeat (10) begin
      step();
      chk("s3_hold_id", 32'(grant_id), 32'd1);
      chk("s3_hold_valid", 32'(grant_valid), 32'd1);
    end
    repeat (2) push_word(1);
    wait_groups(2, 60);
    if (gid_log.size() >= 2) begin
      chk("s3_id0", 32'(gid_log[0]), 32'd1);
      chk("s3_first0", 32'(first_log[0]), 32'd256);
      chk("s3_id1", 32'(gid_log[1]), 32'd0);
    end

    // 4: receiver stops accepting for 20 cycles mid-burst.
    reset_begin();
    repeat (8) push_word(2);
    ready_mode = 1;
    reset_end();
    wait_rx(2, 50);
    ready_mode = 0;
    repeat (20) step();
    chk("s4_frozen_words", 32'(rx.size()), 32'd2);
    chk("s4_frozen_id", 32'(grant_id), 32'd2);
    ready_mode = 1;
    wait_groups(1, 50);
    if (gid_log.size() >= 1) chk("s4_first0", 32'(first_log[0]), 32'd512);

    // 5: asynchronous reset pulse after two words of a burst.
    reset_begin();
    repeat (8) push_word(1);
    ready_mode = 1;
    reset_end();
    wait_rx(2, 50);
    chk("s5_pre_valid", 32'(grant_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("s5_async");
    clear_model();
    repeat (4) push_word(0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive();
    #1;
    sample();
    wait_groups(2, 60);
    if (gid_log.size() >= 2) begin
      chk("s5_id0", 32'(gid_log[0]), 32'd0);
      chk("s5_id1", 32'(gid_log[1]), 32'd1);
      chk("s5_first1", 32'(first_log[1]), 32'd257);
    end

    // 6: requesters 3 and 0 together with last grant at 3.
    reset_begin();
    repeat (4) push_word(0);
    repeat (4) push_word(3);
    ready_mode = 1;
    reset_end();
    wait_groups(2, 60);
    if (gid_log.size() >= 2) begin
      chk("s6_id0", 32'(gid_log[0]), 32'd0);
      chk("s6_id1", 32'(gid_log[1]), 32'd3);
    end

    // Random traffic against the same model.
    reset_begin();
    for (int r = 0; r < 4; r++) push_en[r] = 1'b1;
    push_pct   = 35;
    ready_mode = 2;
    reset_end();
    repeat (250) step();
    chk("random_progress", 32'(gid_log.size() > 10), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
